// File: rtl/matrix_op_sequencer_if.sv
// ALU-side port bundle between the matrix op sequencer (master) and the matrix store (slave).
// Reads are asynchronous; element and dims writes commit on the clock edge.
interface matrix_op_sequencer_if #(
  parameter int DW    = 16,
  parameter int DIM_W = 3
);
  logic [1:0]       rd_slot;
  logic [DIM_W-1:0] rd_row;
  logic [DIM_W-1:0] rd_col;
  logic [DW-1:0]    rd_data;
  logic [DIM_W-1:0] cur_m;
  logic [DIM_W-1:0] cur_n;
  logic [1:0]       wr_slot;
  logic [DIM_W-1:0] wr_row;
  logic [DIM_W-1:0] wr_col;
  logic [DW-1:0]    wr_data;
  logic             wr_we;
  logic [DIM_W-1:0] res_m;
  logic [DIM_W-1:0] res_n;
  logic             dim_we;

  modport master (
    output rd_slot, rd_row, rd_col, wr_slot, wr_row, wr_col, wr_data, wr_we,
           res_m, res_n, dim_we,
    input  rd_data, cur_m, cur_n
  );

  modport slave (
    input  rd_slot, rd_row, rd_col, wr_slot, wr_row, wr_col, wr_data, wr_we,
           res_m, res_n, dim_we,
    output rd_data, cur_m, cur_n
  );
endinterface

// File: rtl/matrix_op_sequencer.sv
// Sequences one ADD / MUL / TRANSPOSE / SCALAR matrix operation over the store's ALU ports:
// operand dims are loaded and checked, then elements are walked row-major and result dims written.
module matrix_op_sequencer #(
  parameter int DW        = 16,
  parameter int DIM_W     = 3,
  parameter int MAX_DIM   = 5,
  parameter int NUM_SLOTS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [1:0]            src_a,
  input  logic [1:0]            src_b,
  input  logic [1:0]            dst,
  input  logic [DW-1:0]         scalar,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code,
  matrix_op_sequencer_if.master bus
);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_MUL = 2'd1;
  localparam logic [1:0] OP_TR  = 2'd2;
  localparam logic [1:0] OP_SCL = 2'd3;
  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_LDA, S_LDB, S_CHK, S_RUN, S_DIMW, S_FIN} state_t;

  state_t           state, nxt;
  logic [1:0]       op_q, a_q, b_q, d_q, code_q, chk_code;
  logic [DW-1:0]    scl_q, a_lat, acc;
  logic [DIM_W-1:0] ma, na, mb, nb, i_q, j_q, k_q, ncol;
  logic [1:0]       ph_q;
  logic             two_src, two_src_in, slot_bad;
  logic             last_i, last_j, last_k, elem_done, elem_last;

  function automatic logic [DW-1:0] wrap_mul(input logic [DW-1:0] x, input logic [DW-1:0] y);
    return x * y;
  endfunction

  function automatic logic [DW-1:0] wrap_add(input logic [DW-1:0] x, input logic [DW-1:0] y);
    return x + y;
  endfunction

  function automatic logic dim_ok(input logic [DIM_W-1:0] d);
    return (d != '0) && (int'(d) <= MAX_DIM);
  endfunction

  function automatic logic slot_ok(input logic [1:0] s);
    return int'(s) < NUM_SLOTS;
  endfunction

  assign two_src_in = (op == OP_ADD) || (op == OP_MUL);
  assign two_src    = (op_q == OP_ADD) || (op_q == OP_MUL);

  // MUL and TRANSPOSE read sources after writing has begun, so dst may not alias them.
  assign slot_bad = !slot_ok(src_a) || (two_src_in && !slot_ok(src_b)) || !slot_ok(dst) ||
                    ((op == OP_MUL) && ((dst == src_a) || (dst == src_b))) ||
                    ((op == OP_TR) && (dst == src_a));

  always_comb begin
    chk_code = 2'd0;
    if (!dim_ok(ma) || !dim_ok(na) || (two_src && (!dim_ok(mb) || !dim_ok(nb))))
      chk_code = 2'd2;
    else if ((op_q == OP_ADD) && ((ma != mb) || (na != nb)))
      chk_code = 2'd3;
    else if ((op_q == OP_MUL) && (na != mb))
      chk_code = 2'd3;
  end

  assign ncol      = (op_q == OP_MUL) ? nb : na;
  assign last_i    = (i_q == ma - ONE);
  assign last_j    = (j_q == ncol - ONE);
  assign last_k    = (k_q == na - ONE);
  assign elem_done = (op_q == OP_ADD) ? (ph_q == 2'd1) :
                     (op_q == OP_MUL) ? (ph_q == 2'd2) : 1'b1;
  assign elem_last = elem_done && last_i && last_j;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt         = state;
    busy        = (state != S_IDLE);
    done        = 1'b0;
    err         = 1'b0;
    err_code    = 2'd0;
    bus.rd_slot = '0;
    bus.rd_row  = '0;
    bus.rd_col  = '0;
    bus.wr_slot = '0;
    bus.wr_row  = '0;
    bus.wr_col  = '0;
    bus.wr_data = '0;
    bus.wr_we   = 1'b0;
    bus.res_m   = '0;
    bus.res_n   = '0;
    bus.dim_we  = 1'b0;
    case (state)
      S_IDLE: if (start) nxt = slot_bad ? S_FIN : S_LDA;
      S_LDA: begin
        bus.rd_slot = a_q;
        nxt         = S_LDB;
      end
      S_LDB: begin
        bus.rd_slot = two_src ? b_q : a_q;
        nxt         = S_CHK;
      end
      S_CHK: nxt = (chk_code != 2'd0) ? S_FIN : S_RUN;
      S_RUN: begin
        bus.rd_slot = a_q;
        bus.rd_row  = i_q;
        bus.rd_col  = j_q;
        bus.wr_slot = d_q;
        bus.wr_row  = i_q;
        bus.wr_col  = j_q;
        case (op_q)
          OP_ADD: begin
            if (ph_q == 2'd1) bus.rd_slot = b_q;
            bus.wr_we   = (ph_q == 2'd1);
            bus.wr_data = wrap_add(a_lat, bus.rd_data);
          end
          OP_SCL: begin
            bus.wr_we   = 1'b1;
            bus.wr_data = wrap_mul(bus.rd_data, scl_q);
          end
          OP_TR: begin
            bus.wr_we   = 1'b1;
            bus.wr_row  = j_q;
            bus.wr_col  = i_q;
            bus.wr_data = bus.rd_data;
          end
          default: begin
            if (ph_q == 2'd1) begin
              bus.rd_slot = b_q;
              bus.rd_row  = k_q;
              bus.rd_col  = j_q;
            end else begin
              bus.rd_col  = k_q;
            end
            bus.wr_we   = (ph_q == 2'd2);
            bus.wr_data = acc;
          end
        endcase
        if (elem_last) nxt = S_DIMW;
      end
      S_DIMW: begin
        bus.dim_we  = 1'b1;
        bus.wr_slot = d_q;
        case (op_q)
          OP_TR:   begin bus.res_m = na; bus.res_n = ma; end
          OP_MUL:  begin bus.res_m = ma; bus.res_n = nb; end
          default: begin bus.res_m = ma; bus.res_n = na; end
        endcase
        nxt = S_FIN;
      end
      S_FIN: begin
        done     = 1'b1;
        err      = (code_q != 2'd0);
        err_code = code_q;
        nxt      = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      d_q    <= '0;
      scl_q  <= '0;
      code_q <= '0;
      ma     <= '0;
      na     <= '0;
      mb     <= '0;
      nb     <= '0;
      i_q    <= '0;
      j_q    <= '0;
      k_q    <= '0;
      ph_q   <= '0;
      a_lat  <= '0;
      acc    <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          op_q   <= op;
          a_q    <= src_a;
          b_q    <= src_b;
          d_q    <= dst;
          scl_q  <= scalar;
          code_q <= slot_bad ? 2'd1 : 2'd0;
        end
        S_LDA: begin
          ma <= bus.cur_m;
          na <= bus.cur_n;
        end
        S_LDB: begin
          mb <= bus.cur_m;
          nb <= bus.cur_n;
        end
        S_CHK: begin
          code_q <= chk_code;
          i_q    <= '0;
          j_q    <= '0;
          k_q    <= '0;
          ph_q   <= '0;
          acc    <= '0;
        end
        S_RUN: begin
          // Phase 0 of ADD and MUL reads the A operand; hold it for the B read that follows.
          if (ph_q == 2'd0) a_lat <= bus.rd_data;
          case (op_q)
            OP_ADD: ph_q <= (ph_q == 2'd0) ? 2'd1 : 2'd0;
            OP_MUL: begin
              case (ph_q)
                2'd0: ph_q <= 2'd1;
                2'd1: begin
                  acc <= wrap_add(acc, wrap_mul(a_lat, bus.rd_data));
                  if (last_k) begin
                    ph_q <= 2'd2;
                  end else begin
                    k_q  <= k_q + ONE;
                    ph_q <= 2'd0;
                  end
                end
                default: begin
                  ph_q <= 2'd0;
                  k_q  <= '0;
                  acc  <= '0;
                end
              endcase
            end
            default: ;
          endcase
          if (elem_done) begin
            if (last_j) begin
              j_q <= '0;
              if (!last_i) i_q <= i_q + ONE;
            end else begin
              j_q <= j_q + ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Directed bench for matrix_op_sequencer: a behavioural matrix store on the ALU ports,
// hand-computed results, done-cycle latencies, error codes, mid-run start and reset.
module tb_matrix_op_sequencer;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = '0, src_a = '0, src_b = '0, dst = '0;
  logic [DW-1:0] scalar = '0;
  logic          busy, done, err;
  logic [1:0]    err_code;

  matrix_op_sequencer_if #(.DW(DW), .DIM_W(3)) bus();

  matrix_op_sequencer #(.DW(DW), .DIM_W(3), .MAX_DIM(5), .NUM_SLOTS(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .dst      (dst),
    .scalar   (scalar),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Matrix store: 4 slots (slot 3 exists only so a faulty address cannot escape the array).
  logic [DW-1:0] mem [4][8][8];
  logic [2:0]    dm [4];
  logic [2:0]    dn [4];
  logic          ld_we = 1'b0, ld_dim_we = 1'b0, clr_cnt = 1'b0;
  logic [1:0]    ld_slot = '0;
  logic [2:0]    ld_row = '0, ld_col = '0, ld_m = '0, ld_n = '0;
  logic [DW-1:0] ld_data = '0;
  int            wr_cnt, dim_cnt;
  logic [2:0]    log_row [64];
  logic [2:0]    log_col [64];

  assign bus.rd_data = mem[bus.rd_slot][bus.rd_row][bus.rd_col];
  assign bus.cur_m   = dm[bus.rd_slot];
  assign bus.cur_n   = dn[bus.rd_slot];

  always @(posedge clk) begin
    if (ld_we)     mem[ld_slot][ld_row][ld_col] <= ld_data;
    if (ld_dim_we) begin dm[ld_slot] <= ld_m; dn[ld_slot] <= ld_n; end
    if (bus.wr_we) mem[bus.wr_slot][bus.wr_row][bus.wr_col] <= bus.wr_data;
    if (bus.dim_we) begin dm[bus.wr_slot] <= bus.res_m; dn[bus.wr_slot] <= bus.res_n; end
    if (clr_cnt) begin
      wr_cnt  <= 0;
      dim_cnt <= 0;
    end else begin
      if (bus.wr_we) begin
        log_row[wr_cnt[5:0]] <= bus.wr_row;
        log_col[wr_cnt[5:0]] <= bus.wr_col;
        wr_cnt <= wr_cnt + 1;
      end
      if (bus.dim_we) dim_cnt <= dim_cnt + 1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic put(input int s, input int r, input int c, input logic [DW-1:0] v);
    @(negedge clk);
    ld_we = 1'b1; ld_slot = s[1:0]; ld_row = r[2:0]; ld_col = c[2:0]; ld_data = v;
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  task automatic set_dims(input int s, input int m, input int n);
    @(negedge clk);
    ld_dim_we = 1'b1; ld_slot = s[1:0]; ld_m = m[2:0]; ld_n = n[2:0];
    @(negedge clk);
    ld_dim_we = 1'b0;
  endtask

  task automatic load_seq(input int s, input int m, input int n, input int base, input int step);
    set_dims(s, m, n);
    for (int r = 0; r < m; r++)
      for (int c = 0; c < n; c++)
        put(s, r, c, DW'(base + step * (r * n + c)));
  endtask

  // Issues one command and counts cycles after the accepting edge until done.
  task automatic run_cmd(input logic [1:0] o, input logic [1:0] a, input logic [1:0] b,
                         input logic [1:0] d, input logic [DW-1:0] s, input int pulse_at,
                         output int cyc, output logic e, output logic [1:0] c);
    @(negedge clk);
    op = o; src_a = a; src_b = b; dst = d; scalar = s; start = 1'b1; clr_cnt = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; clr_cnt = 1'b0;
    cyc = 0; e = 1'b0; c = 2'd0;
    for (int t = 1; t <= 200; t++) begin
      if (done) begin
        cyc = t; e = err; c = err_code;
        break;
      end
      if (t == pulse_at) begin
        start = 1'b1; op = 2'd2; dst = 2'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    @(posedge clk); #1;
    check("busy_after_done", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int         cyc;
  logic       e;
  logic [1:0] c;

  initial begin
    repeat (2) @(posedge clk); #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", {err, err_code}, 0);
    check("rst_strobes", {bus.wr_we, bus.dim_we}, 0);
    check("rst_rd_slot", bus.rd_slot, 0);
    @(negedge clk); rst_n = 1'b1;

    // ADD 2x3
    load_seq(0, 2, 3, 1, 1);
    load_seq(1, 2, 3, 10, 10);
    set_dims(2, 0, 0);
    run_cmd(2'd0, 2'd0, 2'd1, 2'd2, 16'd0, 0, cyc, e, c);
    check("add_cycle", cyc, 17);
    check("add_err", {e, c}, 0);
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 3; k++)
        check("add_elem", mem[2][r][k], 11 * (r * 3 + k + 1));
    check("add_dims", {dm[2], dn[2]}, {3'd2, 3'd3});
    check("add_writes", wr_cnt, 6);
    check("add_dimw", dim_cnt, 1);

    // MUL 2x3 * 3x2
    load_seq(1, 3, 2, 7, 1);
    run_cmd(2'd1, 2'd0, 2'd1, 2'd2, 16'd0, 0, cyc, e, c);
    check("mul_cycle", cyc, 33);
    check("mul_err", {e, c}, 0);
    check("mul_00", mem[2][0][0], 58);
    check("mul_01", mem[2][0][1], 64);
    check("mul_10", mem[2][1][0], 139);
    check("mul_11", mem[2][1][1], 154);
    check("mul_dims", {dm[2], dn[2]}, {3'd2, 3'd2});

    // TRANSPOSE 2x3 -> 3x2
    run_cmd(2'd2, 2'd0, 2'd0, 2'd1, 16'd0, 0, cyc, e, c);
    check("tr_cycle", cyc, 11);
    check("tr_err", {e, c}, 0);
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 2; k++)
        check("tr_elem", mem[1][r][k], k * 3 + r + 1);
    check("tr_dims", {dm[1], dn[1]}, {3'd3, 3'd2});
    check("tr_addr1", {log_row[1], log_col[1]}, {3'd1, 3'd0});
    check("tr_addr2", {log_row[2], log_col[2]}, {3'd2, 3'd0});

    // SCALAR in place, with wrap-around
    set_dims(0, 1, 2);
    put(0, 0, 0, 16'h8000);
    put(0, 0, 1, 16'h0003);
    run_cmd(2'd3, 2'd0, 2'd0, 2'd0, 16'd2, 0, cyc, e, c);
    check("scl_cycle", cyc, 7);
    check("scl_err", {e, c}, 0);
    check("scl_0", mem[0][0][0], 16'h0000);
    check("scl_1", mem[0][0][1], 16'h0006);
    check("scl_dims", {dm[0], dn[0]}, {3'd1, 3'd2});

    // Errors
    run_cmd(2'd0, 2'd0, 2'd1, 2'd3, 16'd0, 0, cyc, e, c);
    check("e1_cycle", cyc, 1);
    check("e1_code", {e, c}, {1'b1, 2'd1});
    check("e1_strobes", wr_cnt + dim_cnt, 0);
    run_cmd(2'd1, 2'd0, 2'd1, 2'd0, 16'd0, 0, cyc, e, c);
    check("e1a_cycle", cyc, 1);
    check("e1a_code", {e, c}, {1'b1, 2'd1});
    check("e1a_strobes", wr_cnt + dim_cnt, 0);
    set_dims(2, 0, 0);
    run_cmd(2'd3, 2'd2, 2'd0, 2'd1, 16'd5, 0, cyc, e, c);
    check("e2_cycle", cyc, 4);
    check("e2_code", {e, c}, {1'b1, 2'd2});
    check("e2_strobes", wr_cnt + dim_cnt, 0);
    set_dims(0, 2, 3);
    set_dims(1, 2, 2);
    run_cmd(2'd1, 2'd0, 2'd1, 2'd2, 16'd0, 0, cyc, e, c);
    check("e3_cycle", cyc, 4);
    check("e3_code", {e, c}, {1'b1, 2'd3});
    check("e3_strobes", wr_cnt + dim_cnt, 0);

    // start pulsed mid-ADD is ignored
    load_seq(0, 2, 3, 1, 1);
    load_seq(1, 2, 3, 10, 10);
    set_dims(2, 0, 0);
    run_cmd(2'd0, 2'd0, 2'd1, 2'd2, 16'd0, 6, cyc, e, c);
    check("pulse_cycle", cyc, 17);
    check("pulse_err", {e, c}, 0);
    check("pulse_elem", mem[2][1][2], 66);
    check("pulse_dims", {dm[2], dn[2]}, {3'd2, 3'd3});
    check("pulse_writes", wr_cnt, 6);

    // Reset in cycle 8 of ADD
    load_seq(2, 2, 3, 0, 0);
    set_dims(2, 1, 1);
    @(negedge clk);
    op = 2'd0; src_a = 2'd0; src_b = 2'd1; dst = 2'd2; start = 1'b1; clr_cnt = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; clr_cnt = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {busy, done, err, err_code}, 0);
    check("mid_rst_strobes", {bus.wr_we, bus.dim_we}, 0);
    check("mid_rst_addr", {bus.rd_row, bus.rd_col, bus.wr_row, bus.wr_col}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_writes", wr_cnt, 2);
    check("rst_elem0", mem[2][0][0], 11);
    check("rst_elem1", mem[2][0][1], 22);
    check("rst_elem2", mem[2][0][2], 0);
    check("rst_dims", {dm[2], dn[2]}, {3'd1, 3'd1});
    run_cmd(2'd0, 2'd0, 2'd1, 2'd2, 16'd0, 0, cyc, e, c);
    check("post_rst_cycle", cyc, 17);
    check("post_rst_elem", mem[2][1][2], 66);
    check("post_rst_dims", {dm[2], dn[2]}, {3'd2, 3'd3});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
